// File: rtl/tmul_row_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tmul_row_sequencer
// Purpose  : Streams up to N_ROWS B-tile rows into the Booth/FMA datapath,
//            then waits out the datapath latency before signalling completion.
// Revision : 1.0 - initial release
// ============================================================================
module tmul_row_sequencer #(
    parameter int N_ROWS   = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [1:0]   mode,
    input  logic [4:0]   k_len,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [255:0] b_row,
    output logic         dp_valid,
    input  logic         dp_ready,
    output logic [255:0] dp_row,
    output logic [3:0]   dp_idx,
    output logic [1:0]   dp_mode,
    output logic         dp_first,
    output logic         dp_last,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int              C_DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [5:0]      C_MAX_ROWS   = 6'(N_ROWS);
    localparam logic [C_DW-1:0] C_DRAIN_INIT = C_DW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [4:0]      r_cnt;
    logic [4:0]      r_k_len;
    logic [C_DW-1:0] r_drain;

    logic w_cfg_legal;
    logic w_load;
    logic w_accept;

    assign w_cfg_legal = (mode != 2'b11) && (k_len != 5'd0) && ({1'b0, k_len} <= C_MAX_ROWS);

    // The output register may be refilled in the same cycle it is drained.
    assign b_ready  = (r_state == S_ISSUE) && (r_cnt < r_k_len) && (!dp_valid || dp_ready);
    assign w_load   = b_valid && b_ready;
    assign w_accept = dp_valid && dp_ready;
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_k_len  <= 5'd0;
            r_drain  <= '0;
            dp_valid <= 1'b0;
            dp_row   <= '0;
            dp_idx   <= 4'd0;
            dp_mode  <= 2'b00;
            dp_first <= 1'b0;
            dp_last  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((r_state != S_IDLE) && abort) begin
                r_state  <= S_IDLE;
                r_cnt    <= 5'd0;
                r_drain  <= '0;
                dp_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_cfg_legal) begin
                                dp_mode <= mode;
                                r_k_len <= k_len;
                                err     <= 1'b0;
                                r_cnt   <= 5'd0;
                                r_state <= S_ISSUE;
                            end else begin
                                // Rejected configuration still completes so software is not left waiting.
                                err  <= 1'b1;
                                done <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (w_load) begin
                            dp_row   <= b_row;
                            dp_idx   <= r_cnt[3:0];
                            dp_first <= (r_cnt == 5'd0);
                            dp_last  <= (r_cnt == r_k_len - 5'd1);
                            dp_valid <= 1'b1;
                            r_cnt    <= r_cnt + 5'd1;
                        end else if (dp_ready) begin
                            dp_valid <= 1'b0;
                        end
                        if (w_accept && dp_last) begin
                            r_state <= S_DRAIN;
                            r_drain <= C_DRAIN_INIT;
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_drain <= r_drain - C_DW'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmul_row_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tmul_row_sequencer
// Purpose  : Table vectors, directed corner sequences and randomized tile
//            operations checked against a row-ordering reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmul_row_sequencer;

    localparam int N_ROWS   = 16;
    localparam int PIPE_LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [1:0]   mode;
    logic [4:0]   k_len;
    logic         b_valid;
    logic         b_ready;
    logic [255:0] b_row;
    logic         dp_valid;
    logic         dp_ready;
    logic [255:0] dp_row;
    logic [3:0]   dp_idx;
    logic [1:0]   dp_mode;
    logic         dp_first;
    logic         dp_last;
    logic         busy;
    logic         done;
    logic         err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tmul_row_sequencer #(.N_ROWS(N_ROWS), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .k_len(k_len), .b_valid(b_valid), .b_ready(b_ready), .b_row(b_row),
        .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_row(dp_row), .dp_idx(dp_idx),
        .dp_mode(dp_mode), .dp_first(dp_first), .dp_last(dp_last), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        logic [1:0] m;
        logic [4:0] k;
        logic       ab;
        logic       exp_busy;
        logic       exp_err;
        logic       exp_done;
    } vec_t;

    vec_t vecs [8];

    task automatic chkb(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic coin(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    // Model: rows must emerge in order 0..k-1, at most one row waits in the
    // output register, and completion lands PIPE_LAT+1 cycles after the last accept.
    task automatic run_op(input logic [1:0] m, input int k, input int vp, input int rp,
                          input int stall_at, input bit abort_drain);
        logic [255:0] rows [16];
        int   b_taken;
        int   dp_cnt;
        int   stall_left;
        logic exp_dpv;
        logic exp_br;
        for (int i = 0; i < 16; i++) rows[i] = rand256();
        b_taken    = 0;
        dp_cnt     = 0;
        stall_left = 3;
        start      = 1'b1;
        mode       = m;
        k_len      = 5'(k);
        abort      = 1'b0;
        b_valid    = coin(vp);
        b_row      = rand256();
        dp_ready   = coin(rp);
        #1;
        chkb("start_busy", busy, 1'b0);
        chkb("start_b_ready", b_ready, 1'b0);
        tick();
        for (int cyc = 0; cyc < 2000 && dp_cnt < k; cyc++) begin
            b_valid  = coin(vp);
            b_row    = (b_taken < k) ? rows[b_taken] : rand256();
            dp_ready = coin(rp);
            if (dp_cnt == stall_at && b_taken > dp_cnt && stall_left > 0) begin
                dp_ready = 1'b0;
                stall_left--;
            end
            start = coin(50);
            mode  = 2'($urandom);
            k_len = 5'($urandom);
            #1;
            exp_dpv = (b_taken > dp_cnt);
            exp_br  = (b_taken < k) && (!exp_dpv || dp_ready);
            chkb("issue_busy", busy, 1'b1);
            chkb("issue_done", done, 1'b0);
            chkb("b_ready", b_ready, exp_br);
            chkb("dp_valid", dp_valid, exp_dpv);
            if (exp_dpv) begin
                chkw("dp_row", dp_row, rows[dp_cnt]);
                chkw("dp_idx", 256'(dp_idx), 256'(dp_cnt));
                chkb("dp_first", dp_first, dp_cnt == 0);
                chkb("dp_last", dp_last, dp_cnt == k - 1);
                chkw("dp_mode", 256'(dp_mode), 256'(m));
            end
            if (b_valid && exp_br) b_taken++;
            if (exp_dpv && dp_ready) dp_cnt++;
            tick();
        end
        if (dp_cnt < k) begin
            n_total++;
            $display("FAIL op_timeout: rows accepted %0d, required %0d", dp_cnt, k);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            return;
        end
        for (int d = 0; d < PIPE_LAT; d++) begin
            b_valid  = coin(50);
            b_row    = rand256();
            dp_ready = coin(50);
            start    = coin(50);
            abort    = abort_drain && (d == 0);
            #1;
            chkb("drain_busy", busy, 1'b1);
            chkb("drain_done", done, 1'b0);
            chkb("drain_dp_valid", dp_valid, 1'b0);
            chkb("drain_b_ready", b_ready, 1'b0);
            tick();
            if (abort_drain) break;
        end
        abort = 1'b0;
        if (abort_drain) begin
            start   = 1'b0;
            b_valid = 1'b0;
            for (int d = 0; d < PIPE_LAT + 2; d++) begin
                #1;
                chkb("abort_busy", busy, 1'b0);
                chkb("abort_done", done, 1'b0);
                chkb("abort_dp_valid", dp_valid, 1'b0);
                tick();
            end
            return;
        end
        start = coin(50);
        #1;
        chkb("done_pulse", done, 1'b1);
        chkb("done_busy", busy, 1'b1);
        tick();
        start = 1'b0;
        #1;
        chkb("post_done", done, 1'b0);
        chkb("post_busy", busy, 1'b0);
        chkb("post_err", err, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        mode     = 2'b00;
        k_len    = 5'd0;
        b_valid  = 1'b0;
        b_row    = '0;
        dp_ready = 1'b0;

        vecs[0] = '{m: 2'b00, k: 5'd0,  ab: 1'b0, exp_busy: 1'b0, exp_err: 1'b1, exp_done: 1'b1};
        vecs[1] = '{m: 2'b01, k: 5'd5,  ab: 1'b0, exp_busy: 1'b1, exp_err: 1'b0, exp_done: 1'b0};
        vecs[2] = '{m: 2'b11, k: 5'd4,  ab: 1'b0, exp_busy: 1'b0, exp_err: 1'b1, exp_done: 1'b1};
        vecs[3] = '{m: 2'b00, k: 5'd17, ab: 1'b0, exp_busy: 1'b0, exp_err: 1'b1, exp_done: 1'b1};
        vecs[4] = '{m: 2'b10, k: 5'd16, ab: 1'b1, exp_busy: 1'b1, exp_err: 1'b0, exp_done: 1'b0};
        vecs[5] = '{m: 2'b10, k: 5'd31, ab: 1'b0, exp_busy: 1'b0, exp_err: 1'b1, exp_done: 1'b1};
        vecs[6] = '{m: 2'b11, k: 5'd0,  ab: 1'b0, exp_busy: 1'b0, exp_err: 1'b1, exp_done: 1'b1};
        vecs[7] = '{m: 2'b10, k: 5'd1,  ab: 1'b0, exp_busy: 1'b1, exp_err: 1'b0, exp_done: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_err", err, 1'b0);
        chkb("rst_dp_valid", dp_valid, 1'b0);
        chkb("rst_b_ready", b_ready, 1'b0);
        chkw("rst_dp_row", dp_row, 256'd0);
        chkw("rst_dp_idx", 256'(dp_idx), 256'd0);
        chkw("rst_dp_mode", 256'(dp_mode), 256'd0);
        chkb("rst_dp_first", dp_first, 1'b0);
        chkb("rst_dp_last", dp_last, 1'b0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            mode     = vecs[i].m;
            k_len    = vecs[i].k;
            abort    = vecs[i].ab;
            start    = 1'b1;
            b_valid  = 1'b0;
            dp_ready = 1'b1;
            tick();
            start = 1'b0;
            abort = 1'b0;
            #1;
            chkb("vec_busy", busy, vecs[i].exp_busy);
            chkb("vec_err", err, vecs[i].exp_err);
            chkb("vec_done", done, vecs[i].exp_done);
            chkb("vec_dp_valid", dp_valid, 1'b0);
            if (vecs[i].exp_busy) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                #1;
                chkb("vec_abort_busy", busy, 1'b0);
                chkb("vec_abort_done", done, 1'b0);
            end else begin
                tick();
                #1;
                chkb("vec_done_once", done, 1'b0);
                chkb("vec_err_sticky", err, 1'b1);
            end
        end

        // Full rate 16 rows, stall at row 1, single row, abort in drain, then a clean run.
        run_op(2'b00, 16, 100, 100, -1, 1'b0);
        run_op(2'b00, 4, 100, 100, 1, 1'b0);
        run_op(2'b01, 1, 100, 100, -1, 1'b0);
        run_op(2'b10, 2, 100, 100, -1, 1'b1);
        run_op(2'b00, 5, 100, 100, -1, 1'b0);

        // Reset pulse while rows are in flight.
        start    = 1'b1;
        mode     = 2'b00;
        k_len    = 5'd8;
        b_valid  = 1'b1;
        b_row    = rand256();
        dp_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chkb("rst_mid_busy", busy, 1'b0);
        chkb("rst_mid_dp_valid", dp_valid, 1'b0);
        chkb("rst_mid_b_ready", b_ready, 1'b0);
        chkw("rst_mid_dp_row", dp_row, 256'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chkb("rst_after_busy", busy, 1'b0);
            chkb("rst_after_done", done, 1'b0);
            chkb("rst_after_dp_valid", dp_valid, 1'b0);
            tick();
        end
        run_op(2'b10, 8, 100, 100, -1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_op(2'($urandom_range(2)), int'($urandom_range(16, 1)),
                   int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                   (n % 3 == 0) ? int'($urandom_range(3)) : -1,
                   ($urandom_range(7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmul_row_sequencer.md
TMUL_ROW_SEQUENCER -- requirements
Module: tmul_row_sequencer

Interface
REQ-001 Parameter N_ROWS, default 16: max B-tile rows per operation, one per shared radix-8 Booth encoder pass.
REQ-002 Parameter PIPE_LAT, default 3: datapath cycles from the last row accept to a stable accumulator.
REQ-003 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low, rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 start  in  1  begin a tile operation; sampled only in IDLE.
REQ-007 abort  in  1  cancel the operation in progress.
REQ-008 mode  in  2  00 FP16, 01 BF16, 10 INT8, 11 illegal.
REQ-009 k_len  in  5  rows to process; legal range 1..N_ROWS.
REQ-010 b_valid  in  1  B-row source valid.
REQ-011 b_ready  out  1  sequencer accepts a B row.
REQ-012 b_row  in  256  16 x 16-bit B elements.
REQ-013 dp_valid  out  1  row presented to the Booth/FMA datapath.
REQ-014 dp_ready  in  1  datapath accepts the row.
REQ-015 dp_row  out  256  registered B row.
REQ-016 dp_idx  out  4  row index, 0-based.
REQ-017 dp_mode  out  2  latched mode.
REQ-018 dp_first / dp_last  out  1 each  first / last row of the operation.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 err  out  1  sticky illegal-configuration flag.

Function
REQ-022 The FSM SHALL have four states: IDLE, ISSUE, DRAIN and DONE.
REQ-023 IDLE: when start=1 with legal mode and k_len, the block SHALL latch mode and k_len, clear err, set cnt=0 and enter ISSUE.
REQ-024 IDLE: when start=1 with mode=11, k_len=0 or k_len>N_ROWS, the block SHALL set err=1, pulse done the next cycle and remain IDLE with busy=0.
REQ-025 start outside IDLE SHALL be ignored; mode and k_len changes after the latch SHALL be ignored.
REQ-026 b_ready SHALL equal (state==ISSUE) && (cnt<k_len) && (!dp_valid || dp_ready).
REQ-027 On b_valid&&b_ready, the next cycle SHALL show dp_row=b_row, dp_idx=cnt, dp_first=(cnt==0), dp_last=(cnt==k_len-1) and dp_valid=1, and cnt SHALL increment.
REQ-028 Latency SHALL be 1 cycle from a B handshake to dp_valid; throughput SHALL be 1 row/cycle while dp_ready=1.
REQ-029 While dp_valid&&!dp_ready, all dp_* outputs SHALL hold stable.
REQ-030 dp_valid SHALL clear on dp_ready when no new row loads in the same cycle; a simultaneous accept and load SHALL replace the register with no bubble.
REQ-031 When dp_valid&&dp_ready&&dp_last, the FSM SHALL enter DRAIN with drain counter = PIPE_LAT-1.
REQ-032 DRAIN SHALL decrement the counter each cycle and enter DONE after exactly PIPE_LAT cycles in DRAIN.
REQ-033 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-034 With k_len=1, the single row SHALL carry both dp_first=1 and dp_last=1.
REQ-035 abort in ISSUE, DRAIN or DONE SHALL force IDLE next cycle, clear dp_valid, cnt and the drain counter, and suppress done; abort SHALL have priority over all other transitions; abort in IDLE SHALL be ignored.
REQ-036 cnt SHALL be 5 bits wide and SHALL never exceed k_len, with no wrap-around.

Reset
REQ-037 rst_n=0 SHALL asynchronously force IDLE, cnt=0, drain counter=0, dp_valid=0, dp_row=0, dp_idx=0, dp_mode=00, dp_first=0, dp_last=0, b_ready=0, busy=0, done=0 and err=0.
REQ-038 Reset mid-operation SHALL discard all rows in flight, and no done SHALL follow.

Verification
REQ-039 mode=00, k_len=16, b_valid and dp_ready held 1 -> dp_idx 0..15 on consecutive cycles, dp_first on idx 0, dp_last on idx 15, done exactly PIPE_LAT+1 cycles after the idx-15 accept.
REQ-040 k_len=4, dp_ready=0 for 3 cycles at idx 1 -> dp_row and dp_idx=1 hold stable, b_ready=0, and no row is lost or duplicated.
REQ-041 mode=11, or k_len=0, or k_len=17 -> err=1, done pulse 1 cycle later, busy stays 0, dp_valid never asserts; a next legal start clears err.
REQ-042 k_len=1, mode=01 -> a single row with dp_first=dp_last=1, dp_mode=01, done after DRAIN.
REQ-043 abort during DRAIN, or rst_n low for one cycle mid-ISSUE -> IDLE next cycle, dp_valid=0, no done; a fresh start then runs normally from idx 0.
